cbd_word_server: RTL
====================

Name: cbd_word_server

Overview:
- Supplies 64-bit randomness words from the Keccak squeeze datapath to the CBD sampler. It is the producer side of the sampler's give_bits/ready word interface.
- Buffers squeezed 64-bit lanes in a small FIFO. Hands one word per four-phase request and counts words per polynomial.
- Signals when a full polynomial's worth of words has been served.
- Sits between the SHAKE lane output and the CBD_3 sampler input.

Parameters:
- DEPTH, 4, FIFO depth in 64-bit words (power of 2, at least 2).
- WORDS_PER_POLY, 24, words served per polynomial (192 bytes for eta=3, 256 coefficients).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous reset, active-low (reset=0 resets)
- start  input  1  level; high enables serving; low aborts to IDLE
- lane_in  input  64  squeezed lane from Keccak
- lane_valid  input  1  lane_in valid
- lane_ready  output  1  FIFO can accept; push when lane_valid && lane_ready
- give_bits  input  1  sampler request (high = wants a word; low = word taken)
- Out  output  64  word presented to sampler; drives sampler In
- ready  output  1  Out valid
- word_count  output  8  words served in current polynomial
- poly_done  output  1  high while in DONE
- fifo_level  output  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, FIFO empty, pointers=0.
  - Out=0, ready=0, word_count=0, poly_done=0, lane_ready=1.
- All outputs are registered except lane_ready and fifo_level, which are decoded from the pointers.
- FIFO:
  - Push when lane_valid && lane_ready.
  - lane_ready = !full, derived from the registered level only. No same-cycle pass-through: when full, a pop does not enable a push that cycle.
  - A push and a pop in the same non-full cycle leave the level unchanged.
  - Pointers wrap modulo DEPTH.
  - FIFO contents persist across start deassertion; only reset clears them.
- Four-phase word handshake:
  - Sampler raises give_bits; server loads Out and raises ready.
  - Sampler drops give_bits, which consumes the word; server drops ready.
  - Out holds its value until the next load.
- States:
  - IDLE: ready=0, word_count=0. If start, go to WAIT_REQ.
  - WAIT_REQ: ready=0. If give_bits && !empty: pop, Out<=head, go to PRESENT. If give_bits && empty: go to FETCH.
  - FETCH: ready=0. When !empty: pop, Out<=head, go to PRESENT. A push arriving at an empty FIFO is visible here the following cycle.
  - PRESENT: ready=1. When give_bits==0: word_count++. If the new count equals WORDS_PER_POLY, go to DONE; otherwise go to WAIT_REQ (ready=0 the next cycle).
  - DONE: poly_done=1, ready=0. Requests are ignored. When start==0, go to IDLE.
- Latency:
  - give_bits sampled high in WAIT_REQ with a non-empty FIFO gives ready=1 on the next cycle.
  - From an empty FIFO, ready rises 2 cycles after the first push.
- Abort: start==0 in any state other than IDLE gives, next cycle, IDLE, ready=0, word_count=0. A word already popped is discarded. The FIFO is not flushed.
- give_bits held high in PRESENT keeps ready=1 and Out stable indefinitely; no further pop occurs.
- word_count is 8 bits. WORDS_PER_POLY must be 255 or less.

Test Plan:
- Reset release, push lanes 0x1111..1 to 0x4444..4 with lane_valid=1 -> lane_ready=0 after the 4th push; fifo_level=4.
- start=1; give_bits=1 for one cycle, then 0 -> Out=0x1111..1 and ready=1 the next cycle; ready=0 one cycle after give_bits falls; word_count=1.
- FIFO empty, give_bits=1; push 0xDEADBEEF_00000001 three cycles later -> state FETCH; ready rises 2 cycles after the push with Out=0xDEADBEEF_00000001.
- Stream 24 incrementing lanes and complete 24 handshakes -> poly_done=1 after the 24th give_bits fall; a 25th give_bits=1 gives ready=0; start=0 -> IDLE, word_count=0.
- FIFO full, push attempted during a pop cycle -> lane_ready=0 and the lane is not accepted; the push is accepted the cycle after fifo_level=3.
- Abort: drop start while in PRESENT -> next cycle ready=0, word_count=0, fifo_level unchanged. Assert reset=0 mid-FETCH -> fifo_level=0 immediately.

Source files
------------

// File: rtl/cbd_word_server.sv
// cbd_word_server: buffers squeezed 64-bit Keccak lanes in a small FIFO and
// hands them one at a time to the CBD sampler over a four-phase
// give_bits/ready handshake. It counts the words served per polynomial and
// flags when a full polynomial's worth has been delivered.
module cbd_word_server #(
  parameter int DEPTH          = 4,
  parameter int WORDS_PER_POLY = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [63:0]              lane_in,
  input  logic                     lane_valid,
  output logic                     lane_ready,
  input  logic                     give_bits,
  output logic [63:0]              Out,
  output logic                     ready,
  output logic [7:0]               word_count,
  output logic                     poly_done,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [7:0]  LAST_WORD  = 8'(WORDS_PER_POLY);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REQ,
    FETCH,
    PRESENT,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [63:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          count_inc;

  // The pointers carry one extra wrap bit, so their difference is the
  // occupancy and full/empty fall out without a separate counter. Because
  // lane_ready depends only on the registered pointers, a pop never opens
  // room for a push in the same cycle.
  assign level      = wr_ptr - rd_ptr;
  assign full       = (level == FULL_LEVEL);
  assign empty      = (level == '0);
  assign lane_ready = !full;
  assign fifo_level = level;
  assign push       = lane_valid && lane_ready;

  // Lane storage; no reset needed because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= lane_in;
    end
  end

  // FIFO pointers; only reset empties the FIFO, abort leaves it intact
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, pop and count strobes; dropping start overrides all
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    count_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = WAIT_REQ;
        end
      end
      WAIT_REQ: begin
        if (give_bits) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = PRESENT;
          end else begin
            state_next = FETCH;
          end
        end
      end
      FETCH: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (!give_bits) begin
          count_inc = 1'b1;
          if (word_count + 8'd1 == LAST_WORD) begin
            state_next = DONE;
          end else begin
            state_next = WAIT_REQ;
          end
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (!start && (state != IDLE)) begin
      state_next = IDLE;
      pop        = 1'b0;
      count_inc  = 1'b0;
    end
  end

  // Registered outputs, decoded from the upcoming state so they line up
  // with it; Out only changes when a word is popped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Out        <= '0;
      ready      <= 1'b0;
      poly_done  <= 1'b0;
      word_count <= '0;
    end else begin
      ready     <= (state_next == PRESENT);
      poly_done <= (state_next == DONE);
      if (state_next == IDLE) begin
        word_count <= '0;
      end else if (count_inc) begin
        word_count <= word_count + 8'd1;
      end
      if (pop) begin
        Out <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule
